seq_squarer: RTL

- Iterative shift-and-add squarer: accepts an unsigned WIDTH-bit operand and returns its exact 2*WIDTH-bit square.
- Inverse operation of the CORDIC hyperbolic square-root datapath.
- Used in the sqrt block's self-check path (square the root, compare against the radicand) and as a standalone arithmetic unit.
- Start/done handshake; one accumulate step per clock.

---
 rtl/seq_squarer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_squarer.sv
// seq_squarer -- iterative shift-and-add squarer.
//
// Squares an unsigned WIDTH-bit operand into an exact 2*WIDTH-bit result.
// Each CALC cycle folds one multiplier bit into the accumulator, so the
// result is available WIDTH+1 cycles after start is accepted.
//
// Optional build macro: SQ_EARLY_EXIT_EN
//   When defined, CALC ends as soon as no set multiplier bits remain.
//   Latency becomes (highest set bit index of x_in) + 2, minimum 2.
//   When undefined, latency is fixed and no zero-detect logic exists.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   request pulse, sampled only in IDLE
//   x_in    WIDTH-bit unsigned operand, captured with start
//   ready   high in IDLE
//   busy    high in CALC
//   done    one-cycle pulse in DONE
//   sq_out  2*WIDTH-bit result, valid from the done cycle onward
//
// state | meaning
// ------+------------------------------------------------------
// IDLE  | waiting for start; ready=1
// CALC  | one shift-and-add step per cycle; busy=1
// DONE  | sq_out holds the new square; done=1 for this cycle

module seq_squarer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   sq_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier_shr;
    logic                 last_step;

    always_comb begin
        acc_sum    = mplier[0] ? (acc + mcand) : acc;
        mplier_shr = mplier >> 1;
`ifdef SQ_EARLY_EXIT_EN
        // No remaining multiplier bits means every further step adds zero.
        last_step  = (cnt == LAST_CNT) || (mplier_shr == '0);
`else
        last_step  = (cnt == LAST_CNT);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            sq_out <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, x_in};
                        mplier <= x_in;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_CALC;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                S_CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier_shr;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        // Result lands together with done.
                        sq_out <= acc_sum;
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
